// File: rtl/ped_button_request.sv
// Pedestrian push-button front end: synchroniser, debouncer, press-edge detector and request FSM.
// Define PED_WAIT_BLINK_EN to make the WAIT lamp blink while a request is pending.
module ped_button_request #(
    parameter int unsigned TIMER_SCALE      = 16000000,
    parameter int unsigned DEBOUNCE_TICKS   = 320000,
    parameter int unsigned LOCKOUT_SECONDS  = 2,
    parameter int unsigned BLINK_HALF_TICKS = 8000000
) (
    input  logic       i_pin3_clk_16mhz,
    input  logic       i_rst,
    input  logic       i_pin2_button,
    input  logic       i_ped_served,
    output logic       o_ped_request,
    output logic       o_pin9_wait,
    output logic [7:0] o_press_count
);

    localparam int              DB_W      = $clog2(DEBOUNCE_TICKS);
    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_TICKS - 1);
    localparam logic [31:0]     LOCK_LAST = 32'(64'(LOCKOUT_SECONDS) * 64'(TIMER_SCALE) - 64'd1);

    if (DEBOUNCE_TICKS < 2 || LOCKOUT_SECONDS < 1 || BLINK_HALF_TICKS < 1) begin : g_bad_params
        $error("ped_button_request: parameter below its minimum");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        LOCKOUT = 2'd2
    } state_t;

    logic            sync1, sync2;
    logic            pressed_s;
    logic            db, db_q;
    logic [DB_W-1:0] db_cnt;
    logic            press_evt;

    state_t          state, state_next;
    logic [7:0]      press_count, count_next;
    logic [31:0]     lock_timer, lock_next;
    logic            req_q;

    assign pressed_s = ~sync2;
    assign press_evt = db & ~db_q;

    // NOTE: non-blocking assignments make sync1 -> sync2 a true two-stage chain.
    always_ff @(posedge i_pin3_clk_16mhz) begin
        if (i_rst) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            db     <= 1'b0;
            db_q   <= 1'b0;
            db_cnt <= '0;
        end else begin
            sync1 <= i_pin2_button;
            sync2 <= sync1;
            db_q  <= db;
            if (pressed_s == db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db     <= pressed_s;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        state_next = state;
        count_next = press_count;
        lock_next  = lock_timer;
        case (state)
            IDLE: begin
                if (press_evt) begin
                    state_next = REQUEST;
                    if (press_count != 8'hFF) count_next = press_count + 8'd1;
                end
            end
            REQUEST: begin
                if (i_ped_served) begin
                    state_next = LOCKOUT;
                    lock_next  = '0;
                end
            end
            LOCKOUT: begin
                if (lock_timer == LOCK_LAST) begin
                    state_next = IDLE;
                    lock_next  = '0;
                end else begin
                    lock_next = lock_timer + 32'd1;
                end
            end
            default: begin
                state_next = IDLE;
                lock_next  = '0;
            end
        endcase
    end

    always_ff @(posedge i_pin3_clk_16mhz) begin
        if (i_rst) begin
            state       <= IDLE;
            press_count <= '0;
            lock_timer  <= '0;
            req_q       <= 1'b0;
        end else begin
            state       <= state_next;
            press_count <= count_next;
            lock_timer  <= lock_next;
            req_q       <= (state_next == REQUEST);
        end
    end

    assign o_ped_request = req_q;
    assign o_press_count = press_count;

`ifdef PED_WAIT_BLINK_EN
    localparam int              BL_W    = $clog2(BLINK_HALF_TICKS + 1);
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_HALF_TICKS - 1);

    logic [BL_W-1:0] blink_cnt;
    logic            wait_q;

    // Lamp starts lit on the first REQUEST cycle; the phase restarts on every entry.
    always_ff @(posedge i_pin3_clk_16mhz) begin
        if (i_rst) begin
            blink_cnt <= '0;
            wait_q    <= 1'b0;
        end else if (state_next == REQUEST && state != REQUEST) begin
            blink_cnt <= '0;
            wait_q    <= 1'b1;
        end else if (state_next == REQUEST) begin
            if (blink_cnt == BL_LAST) begin
                blink_cnt <= '0;
                wait_q    <= ~wait_q;
            end else begin
                blink_cnt <= blink_cnt + BL_W'(1);
            end
        end else begin
            blink_cnt <= '0;
            wait_q    <= 1'b0;
        end
    end

    assign o_pin9_wait = wait_q;
`else
    assign o_pin9_wait = req_q;
`endif

endmodule

// File: tb/tb_ped_button_request.sv
// Self-checking bench for ped_button_request: expected press counts are queued when a
// press is driven and compared when o_ped_request rises; timing/lockout/lamp checked inline.
module tb_ped_button_request;

    localparam int TS = 100;
    localparam int DT = 4;
    localparam int LS = 2;
    localparam int BH = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       button = 1'b1;
    logic       served = 1'b0;
    logic       ped_request;
    logic       pin9_wait;
    logic [7:0] press_count;

    int checks = 0;
    int errors = 0;
    int sb[$];
    int exp_count = 0;

    always #5 clk = ~clk;

    ped_button_request #(
        .TIMER_SCALE     (TS),
        .DEBOUNCE_TICKS  (DT),
        .LOCKOUT_SECONDS (LS),
        .BLINK_HALF_TICKS(BH)
    ) dut (
        .i_pin3_clk_16mhz(clk),
        .i_rst           (rst),
        .i_pin2_button   (button),
        .i_ped_served    (served),
        .o_ped_request   (ped_request),
        .o_pin9_wait     (pin9_wait),
        .o_press_count   (press_count)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_accept();
        exp_count = (exp_count < 255) ? exp_count + 1 : 255;
        sb.push_back(exp_count);
    endtask

    task automatic wait_req(input logic level, input int budget, output int edges);
        edges = 0;
        while (ped_request !== level && edges < budget) begin
            tick();
            edges++;
        end
        if (ped_request !== level) check("timeout_req", ped_request, level);
    endtask

    task automatic serve();
        served = 1'b1;
        tick();
        served = 1'b0;
    endtask

    // Scoreboard side: every new request must match the oldest queued count.
    logic req_prev = 1'b0;
    always @(negedge clk) begin : monitor
        int exp_v;
        if (ped_request === 1'b1 && req_prev !== 1'b1) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_req", ped_request, 0);
            end else begin
                exp_v = sb.pop_front();
                check("sb_count", press_count, exp_v);
            end
        end
        req_prev = ped_request;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog simulation did not complete checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int e;
        int hits;
        int exp_lamp;

        // Reset with the button already held down.
        rst = 1'b1;
        button = 1'b0;
        served = 1'b0;
        tick(3);
        check("rst_req", ped_request, 0);
        check("rst_wait", pin9_wait, 0);
        check("rst_count", press_count, 0);
        rst = 1'b0;
        expect_accept();
        tick(6);
        check("rst_lat_edge6", ped_request, 0);
        tick(1);
        check("rst_lat_edge7", ped_request, 1);
        check("rst_first_wait", pin9_wait, 1);
        check("rst_first_count", press_count, 1);

        // Reset while a request is pending clears everything at the next edge.
        rst = 1'b1;
        button = 1'b1;
        tick(1);
        check("midrst_req", ped_request, 0);
        check("midrst_wait", pin9_wait, 0);
        check("midrst_count", press_count, 0);
        exp_count = 0;
        tick(2);
        rst = 1'b0;
        tick(10);

        // Bounce: 2 low / 2 high for 20 cycles, then released.
        hits = 0;
        for (int i = 0; i < 20; i++) begin
            button = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
            tick();
            hits += int'(ped_request);
        end
        button = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            hits += int'(ped_request);
        end
        check("bounce_req_cycles", hits, 0);
        check("bounce_count", press_count, 0);

        // Clean press.
        expect_accept();
        button = 1'b0;
        wait_req(1'b1, 20, e);
        check("press_latency", e, DT + 3);
        check("press_count", press_count, 1);
        check("press_wait", pin9_wait, 1);

        // Service, then a press whose edge lands on the last lockout cycle.
        serve();
        check("serve_drop_req", ped_request, 0);
        check("serve_drop_wait", pin9_wait, 0);
        button = 1'b1;
        hits = 0;
        for (int i = 0; i < 193; i++) begin
            tick();
            hits += int'(ped_request);
        end
        button = 1'b0;
        for (int i = 0; i < 27; i++) begin
            tick();
            hits += int'(ped_request);
        end
        check("lockout_req_cycles", hits, 0);
        check("lockout_count", press_count, 1);

        // Fresh press after lockout.
        button = 1'b1;
        tick(10);
        expect_accept();
        button = 1'b0;
        wait_req(1'b1, 20, e);
        check("fresh_latency", e, DT + 3);
        check("fresh_count", press_count, 2);

        serve();
        button = 1'b1;
        tick(205);

        // Press event and served in the same IDLE cycle.
        expect_accept();
        button = 1'b0;
        tick(DT + 2);
        served = 1'b1;
        tick(1);
        served = 1'b0;
        check("sim_idle_req", ped_request, 1);
        check("sim_idle_count", press_count, 3);

        // Repeat press while REQUEST is pending.
        button = 1'b1;
        tick(10);
        button = 1'b0;
        tick(10);
        check("repeat_req", ped_request, 1);
        check("repeat_count", press_count, 3);

        // Press event and served together in REQUEST.
        button = 1'b1;
        tick(10);
        button = 1'b0;
        tick(DT + 2);
        served = 1'b1;
        tick(1);
        served = 1'b0;
        check("sim_req_req", ped_request, 0);
        check("sim_req_count", press_count, 3);
        button = 1'b1;
        tick(205);
        check("idle_wait", pin9_wait, 0);

        // WAIT lamp pattern over the first 25 REQUEST cycles.
        expect_accept();
        button = 1'b0;
        wait_req(1'b1, 20, e);
        for (int c = 0; c < 25; c++) begin
`ifdef PED_WAIT_BLINK_EN
            exp_lamp = (c < BH) ? 1 : ((c < 2 * BH) ? 0 : 1);
`else
            exp_lamp = 1;
`endif
            check($sformatf("lamp_cycle%0d", c), pin9_wait, exp_lamp);
            tick();
        end

        // Saturation: requests 5..260, each served and released through lockout.
        for (int i = 0; i < 256; i++) begin
            serve();
            button = 1'b1;
            tick(195);
            expect_accept();
            button = 1'b0;
            wait_req(1'b1, 20, e);
            check("sat_latency", e, DT + 3);
        end
        check("sat_count", press_count, 255);

        serve();
        tick(2);
        check("final_lockout_wait", pin9_wait, 0);
        check("final_lockout_req", ped_request, 0);
        check("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ped_button_request.md
Name: ped_button_request

Overview:
- Upstream input stage for the traffic-light controller. Conditions the raw pedestrian push-button:
  - 2-FF synchroniser
  - debouncer
  - press-edge detector
- Holds a latched pedestrian request until the controller pulses "served".
- After service, applies a lockout window, then accepts presses again.
- Drives the "WAIT" lamp and a saturating 8-bit count of accepted requests for diagnostics.

Parameters:
- TIMER_SCALE, 16000000, clock ticks per second (same meaning as in the controller).
- DEBOUNCE_TICKS, 320000, cycles the synchronised input must stay stable before the debounced level changes (20 ms at 16 MHz); min 2.
- LOCKOUT_SECONDS, 2, seconds after service during which presses are ignored; min 1.
- BLINK_HALF_TICKS, 8000000, half-period of the WAIT-lamp blink in cycles; used only with the optional feature.

Ports:
- i_pin3_clk_16mhz  in  1  system clock, 16 MHz.
- i_rst  in  1  synchronous, active-high reset.
- i_pin2_button  in  1  raw push-button, asynchronous, active-low (pull-up; 0 = pressed).
- i_ped_served  in  1  one-cycle pulse from the controller when the pedestrian phase begins.
- o_ped_request  out  1  registered; high while a request is pending.
- o_pin9_wait  out  1  WAIT lamp, active-high.
- o_press_count  out  8  accepted-request count, saturates at 255.

Behaviour:
- Clock and reset: single clock i_pin3_clk_16mhz; reset is synchronous and active-high on i_rst; all registers update on the rising edge.
- Reset values:
  - sync FFs = 1 (released); debounced level = 0 (released); debounce counter = 0
  - state = IDLE; lockout/blink timers = 0
  - o_ped_request = 0; o_pin9_wait = 0; o_press_count = 0
- Reset asserted mid-operation drops any pending request at the next edge with no residual state.
- Synchroniser: sync1 <= i_pin2_button; sync2 <= sync1. pressed_s = ~sync2.
- Debouncer (counter width = clog2(DEBOUNCE_TICKS)):
  - if pressed_s == db: counter <= 0.
  - else if counter == DEBOUNCE_TICKS-1: db <= pressed_s, counter <= 0.
  - else: counter <= counter+1.
  - Any bounce (pressed_s returning to db) restarts the count.
- Press event: press_evt = db & ~db_q, where db_q is db delayed one cycle. Combinational, one cycle wide. A release never generates an event.
- Latency: o_ped_request rises after edge number DEBOUNCE_TICKS+3, counting the first edge that samples the button low as edge 1, given a clean press.
- FSM states and transitions:
  - IDLE: press_evt -> REQUEST; o_press_count increments, saturating at 255. i_ped_served is ignored.
  - REQUEST: further press_evt ignored (no count). i_ped_served -> LOCKOUT; lockout timer cleared.
  - LOCKOUT: timer increments every cycle. At LOCKOUT_SECONDS*TIMER_SCALE-1 -> IDLE. press_evt and i_ped_served are ignored. Lockout timer is 32 bits wide, full width product.
  - Illegal state -> IDLE.
- Simultaneous events:
  - press_evt and i_ped_served in IDLE: go to REQUEST.
  - Both in REQUEST: go to LOCKOUT, no count.
  - A button held through the end of LOCKOUT does not re-request; a new press edge is required.
- Outputs:
  - o_ped_request = 1 exactly while state == REQUEST (registered with the state).
  - o_pin9_wait = o_ped_request unless the optional feature is enabled.
  - o_press_count is registered.

Optional Feature:
- Macro: PED_WAIT_BLINK_EN.
- Defined:
  - In REQUEST, o_pin9_wait blinks. It is 1 on the first REQUEST cycle and toggles every BLINK_HALF_TICKS cycles.
  - The blink counter is cleared on every entry to REQUEST.
  - o_pin9_wait is 0 in IDLE and LOCKOUT.
- Undefined: the blink counter is absent, and o_pin9_wait is steady and identical to o_ped_request.

Test Plan:
- All scenarios use parameters TIMER_SCALE=100, DEBOUNCE_TICKS=4, LOCKOUT_SECONDS=2, BLINK_HALF_TICKS=10.
- Reset: hold i_rst 3 cycles with button low -> o_ped_request=0, o_pin9_wait=0, o_press_count=0. First request appears 7 edges after reset release.
- Clean press: button low from edge 1 and held -> o_ped_request=1 after edge 7; o_press_count=1; o_pin9_wait=1.
- Bounce: button toggles low/high every 2 cycles for 20 cycles, then stays high -> no request; o_press_count stays 0.
- Service and lockout:
  - Pulse i_ped_served in REQUEST -> o_ped_request=0 next edge.
  - A press during the next 200 cycles is ignored.
  - After 200 cycles a fresh press (release then press) gives o_press_count=2.
- Simultaneous: press_evt and i_ped_served in the same cycle from IDLE -> REQUEST entered, o_press_count increments. Repeat press during REQUEST -> count unchanged.
- Saturation and blink:
  - 260 serviced requests -> o_press_count=255.
  - With PED_WAIT_BLINK_EN, in REQUEST the lamp is 1 for cycles 0-9, 0 for cycles 10-19, 1 from cycle 20.
  - Without the macro, the lamp is steady 1.
